alu_branch_unit: RTL and testbench

//  Execute-stage compute block of the single-cycle RV32I core.

---
 rtl/alu_branch_unit_pkg.sv | 30 +++
 rtl/alu_branch_unit_core.sv | 42 ++++
 rtl/alu_branch_unit.sv | 101 ++++++++++
 tb/tb_alu_branch_unit.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_branch_unit_pkg.sv
// rtl/alu_branch_unit_pkg.sv - shared ALU class and control-code constants
// Used by the execute stage and by core-level main control and branch logic.
package alu_branch_unit_pkg;

  localparam int XLEN = 32;

  localparam logic [2:0] ALUOP_ADD    = 3'b000;
  localparam logic [2:0] ALUOP_BRANCH = 3'b001;
  localparam logic [2:0] ALUOP_RTYPE  = 3'b010;
  localparam logic [2:0] ALUOP_ITYPE  = 3'b011;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [3:0] ALU_SLTU = 4'b1000;
  localparam logic [3:0] ALU_XOR  = 4'b1001;
  localparam logic [3:0] ALU_SLL  = 4'b1010;
  localparam logic [3:0] ALU_SRL  = 4'b1011;
  localparam logic [3:0] ALU_SRA  = 4'b1100;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

endpackage

// File: rtl/alu_branch_unit_core.sv
// rtl/alu_branch_unit_core.sv - integer ALU datapath: ctrl, Ra, Rb -> Rc, Z
// Unknown control codes yield a zero result.
module alu_core
  import alu_branch_unit_pkg::*;
#(
  parameter int XLEN = alu_branch_unit_pkg::XLEN
) (
  input  logic [3:0]      ctrl_i,
  input  logic [XLEN-1:0] ra_i,
  input  logic [XLEN-1:0] rb_i,
  output logic [XLEN-1:0] rc_o,
  output logic            z_o
);

  logic [4:0] shamt;
  logic       lt_signed;
  logic       lt_unsigned;

  assign shamt       = rb_i[4:0];
  assign lt_signed   = $signed(ra_i) < $signed(rb_i);
  assign lt_unsigned = ra_i < rb_i;

  always_comb begin
    rc_o = '0;
    case (ctrl_i)
      ALU_AND:  rc_o = ra_i & rb_i;
      ALU_OR:   rc_o = ra_i | rb_i;
      ALU_ADD:  rc_o = ra_i + rb_i;
      ALU_SUB:  rc_o = ra_i - rb_i;
      ALU_SLT:  rc_o = {{(XLEN-1){1'b0}}, lt_signed};
      ALU_SLTU: rc_o = {{(XLEN-1){1'b0}}, lt_unsigned};
      ALU_XOR:  rc_o = ra_i ^ rb_i;
      ALU_SLL:  rc_o = ra_i << shamt;
      ALU_SRL:  rc_o = ra_i >> shamt;
      ALU_SRA:  rc_o = $signed(ra_i) >>> shamt;
      default:  rc_o = '0;
    endcase
  end

  assign z_o = (rc_o == '0);

endmodule

// File: rtl/alu_branch_unit.sv
// rtl/alu_branch_unit.sv - execute stage: ALU decode, compute, branch decision
// REG_OUT selects combinational or one-cycle registered outputs.
module alu_branch_unit
  import alu_branch_unit_pkg::*;
#(
  parameter int XLEN    = alu_branch_unit_pkg::XLEN,
  parameter bit REG_OUT = 1'b0
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic [2:0]      i_ALUOp,
  input  logic [2:0]      i_Funct3,
  input  logic [6:0]      i_Funct7,
  input  logic [XLEN-1:0] i_Ra,
  input  logic [XLEN-1:0] i_Rb,
  input  logic            i_Branch,
  output logic [3:0]      o_ALUControlLines,
  output logic [XLEN-1:0] o_Rc,
  output logic            o_Z,
  output logic            o_DoBranch
);

  logic [3:0]      ctrl_d, ctrl_q;
  logic [XLEN-1:0] rc_d, rc_q;
  logic            z_d, z_q;
  logic            db_d, db_q;
  logic            br_cond;

  // Only funct7[5] selects between operations; the rest is opcode/immediate.
  logic unused_funct7;
  assign unused_funct7 = ^{i_Funct7[6], i_Funct7[4:0]};

  always_comb begin
    ctrl_d = ALU_ADD;
    case (i_ALUOp)
      ALUOP_BRANCH: begin
        case (i_Funct3[2:1])
          2'b10:   ctrl_d = ALU_SLT;
          2'b11:   ctrl_d = ALU_SLTU;
          default: ctrl_d = ALU_SUB;
        endcase
      end
      ALUOP_RTYPE, ALUOP_ITYPE: begin
        case (i_Funct3)
          // I-type funct7 bits are immediate, so only R-type may select SUB.
          3'b000:  ctrl_d = (i_ALUOp == ALUOP_RTYPE && i_Funct7[5]) ? ALU_SUB : ALU_ADD;
          3'b001:  ctrl_d = ALU_SLL;
          3'b010:  ctrl_d = ALU_SLT;
          3'b011:  ctrl_d = ALU_SLTU;
          3'b100:  ctrl_d = ALU_XOR;
          3'b101:  ctrl_d = i_Funct7[5] ? ALU_SRA : ALU_SRL;
          3'b110:  ctrl_d = ALU_OR;
          default: ctrl_d = ALU_AND;
        endcase
      end
      default: ctrl_d = ALU_ADD;
    endcase
  end

  alu_core #(.XLEN(XLEN)) u_core (
    .ctrl_i (ctrl_d),
    .ra_i   (i_Ra),
    .rb_i   (i_Rb),
    .rc_o   (rc_d),
    .z_o    (z_d)
  );

  always_comb begin
    br_cond = 1'b0;
    case (i_Funct3)
      F3_BEQ:           br_cond = z_d;
      F3_BNE:           br_cond = ~z_d;
      F3_BLT, F3_BLTU:  br_cond = rc_d[0];
      F3_BGE, F3_BGEU:  br_cond = ~rc_d[0];
      default:          br_cond = 1'b0;
    endcase
  end

  assign db_d = i_Branch & br_cond;

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      ctrl_q <= '0;
      rc_q   <= '0;
      z_q    <= 1'b0;
      db_q   <= 1'b0;
    end else begin
      ctrl_q <= ctrl_d;
      rc_q   <= rc_d;
      z_q    <= z_d;
      db_q   <= db_d;
    end
  end

  // With REG_OUT=0 the register bank has no fanout and is trimmed away.
  assign o_ALUControlLines = REG_OUT ? ctrl_q : ctrl_d;
  assign o_Rc              = REG_OUT ? rc_q   : rc_d;
  assign o_Z               = REG_OUT ? z_q    : z_d;
  assign o_DoBranch        = REG_OUT ? db_q   : db_d;

endmodule

// File: tb/tb_alu_branch_unit.sv
// tb/tb_alu_branch_unit.sv - bench for alu_branch_unit, combinational and registered builds
module tb_alu_branch_unit;

  typedef struct packed {
    logic [3:0]  ctrl;
    logic [31:0] rc;
    logic        z;
    logic        db;
  } exp_t;

  typedef struct {
    logic [2:0]  op;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] a;
    logic [31:0] b;
    logic        br;
    logic [3:0]  ctrl;
    logic [31:0] rc;
    logic        z;
    logic        db;
  } vec_t;

  logic        clk;
  logic        rst;
  logic [2:0]  aluop;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [31:0] ra;
  logic [31:0] rb;
  logic        br;

  logic [3:0]  c_ctrl, r_ctrl;
  logic [31:0] c_rc, r_rc;
  logic        c_z, r_z, c_db, r_db;

  int n_vec  = 0;
  int n_miss = 0;

  exp_t exp_now;
  exp_t exp_q;
  logic reg_valid = 1'b0;
  vec_t vt[$];

  alu_branch_unit #(.XLEN(32), .REG_OUT(1'b0)) dut_c (
    .i_clk(clk), .i_rst(rst), .i_ALUOp(aluop), .i_Funct3(f3), .i_Funct7(f7),
    .i_Ra(ra), .i_Rb(rb), .i_Branch(br),
    .o_ALUControlLines(c_ctrl), .o_Rc(c_rc), .o_Z(c_z), .o_DoBranch(c_db)
  );

  alu_branch_unit #(.XLEN(32), .REG_OUT(1'b1)) dut_r (
    .i_clk(clk), .i_rst(rst), .i_ALUOp(aluop), .i_Funct3(f3), .i_Funct7(f7),
    .i_Ra(ra), .i_Rb(rb), .i_Branch(br),
    .o_ALUControlLines(r_ctrl), .o_Rc(r_rc), .o_Z(r_z), .o_DoBranch(r_db)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: pick the RV32I operation, do the arithmetic, and decide branches
  // from a direct comparison of the operands when the class is BRANCH.
  function automatic exp_t model(input logic [2:0] op, input logic [2:0] fn3,
                                 input logic [6:0] fn7, input logic [31:0] a,
                                 input logic [31:0] b, input logic isbr);
    exp_t e;
    logic cond;
    e = '0;
    if (op == 3'd1) begin
      if (fn3 == 3'd4 || fn3 == 3'd5)      e.ctrl = 4'b0111;
      else if (fn3 == 3'd6 || fn3 == 3'd7) e.ctrl = 4'b1000;
      else                                 e.ctrl = 4'b0110;
    end else if (op == 3'd2 || op == 3'd3) begin
      case (fn3)
        3'd0: e.ctrl = (op == 3'd2 && fn7[5]) ? 4'b0110 : 4'b0010;
        3'd1: e.ctrl = 4'b1010;
        3'd2: e.ctrl = 4'b0111;
        3'd3: e.ctrl = 4'b1000;
        3'd4: e.ctrl = 4'b1001;
        3'd5: e.ctrl = fn7[5] ? 4'b1100 : 4'b1011;
        3'd6: e.ctrl = 4'b0001;
        default: e.ctrl = 4'b0000;
      endcase
    end else begin
      e.ctrl = 4'b0010;
    end
    case (e.ctrl)
      4'b0000: e.rc = a & b;
      4'b0001: e.rc = a | b;
      4'b0010: e.rc = a + b;
      4'b0110: e.rc = a - b;
      4'b0111: e.rc = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'b1000: e.rc = (a < b) ? 32'd1 : 32'd0;
      4'b1001: e.rc = a ^ b;
      4'b1010: e.rc = a << b[4:0];
      4'b1011: e.rc = a >> b[4:0];
      4'b1100: e.rc = $signed(a) >>> b[4:0];
      default: e.rc = 32'd0;
    endcase
    e.z = (e.rc == 32'd0);
    if (op == 3'd1) begin
      case (fn3)
        3'd0: cond = (a == b);
        3'd1: cond = (a != b);
        3'd4: cond = ($signed(a) < $signed(b));
        3'd5: cond = ($signed(a) >= $signed(b));
        3'd6: cond = (a < b);
        3'd7: cond = (a >= b);
        default: cond = 1'b0;
      endcase
    end else begin
      case (fn3)
        3'd0: cond = e.z;
        3'd1: cond = !e.z;
        3'd4, 3'd6: cond = e.rc[0];
        3'd5, 3'd7: cond = !e.rc[0];
        default: cond = 1'b0;
      endcase
    end
    e.db = isbr & cond;
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
    end
  endtask

  assign exp_now = model(aluop, f3, f7, ra, rb, br);

  always @(posedge clk) begin
    exp_q     <= rst ? exp_now : '0;
    reg_valid <= 1'b1;
  end

  always @(negedge clk) begin
    chk("comb_ctrl", {28'd0, c_ctrl}, {28'd0, exp_now.ctrl});
    chk("comb_rc", c_rc, exp_now.rc);
    chk("comb_z", {31'd0, c_z}, {31'd0, exp_now.z});
    chk("comb_db", {31'd0, c_db}, {31'd0, exp_now.db});
    if (reg_valid) begin
      chk("reg_ctrl", {28'd0, r_ctrl}, {28'd0, exp_q.ctrl});
      chk("reg_rc", r_rc, exp_q.rc);
      chk("reg_z", {31'd0, r_z}, {31'd0, exp_q.z});
      chk("reg_db", {31'd0, r_db}, {31'd0, exp_q.db});
    end
  end

  task automatic drive(input vec_t v);
    aluop = v.op; f3 = v.f3; f7 = v.f7; ra = v.a; rb = v.b; br = v.br;
  endtask

  task automatic chk_reg_zero(input string name);
    chk({name, "_ctrl"}, {28'd0, r_ctrl}, 32'd0);
    chk({name, "_rc"}, r_rc, 32'd0);
    chk({name, "_z"}, {31'd0, r_z}, 32'd0);
    chk({name, "_db"}, {31'd0, r_db}, 32'd0);
  endtask

  initial begin
    exp_t pin;
    //          op    f3    f7      a             b             br    ctrl     rc            z     db
    vt.push_back('{3'd2, 3'd0, 7'h20, 32'd5,        32'd7,        1'b0, 4'b0110, 32'hFFFFFFFE, 1'b0, 1'b0});
    vt.push_back('{3'd3, 3'd5, 7'h20, 32'h80000000, 32'd4,        1'b0, 4'b1100, 32'hF8000000, 1'b0, 1'b0});
    vt.push_back('{3'd3, 3'd5, 7'h00, 32'h80000000, 32'd4,        1'b0, 4'b1011, 32'h08000000, 1'b0, 1'b0});
    vt.push_back('{3'd3, 3'd0, 7'h20, 32'd1,        32'hFFFFFFFF, 1'b0, 4'b0010, 32'h00000000, 1'b1, 1'b0});
    vt.push_back('{3'd1, 3'd0, 7'h00, 32'h1234,     32'h1234,     1'b1, 4'b0110, 32'h00000000, 1'b1, 1'b1});
    vt.push_back('{3'd1, 3'd1, 7'h00, 32'h1234,     32'h1234,     1'b1, 4'b0110, 32'h00000000, 1'b1, 1'b0});
    vt.push_back('{3'd1, 3'd0, 7'h00, 32'h1234,     32'h1234,     1'b0, 4'b0110, 32'h00000000, 1'b1, 1'b0});
    vt.push_back('{3'd1, 3'd4, 7'h00, 32'hFFFFFFFF, 32'd1,        1'b1, 4'b0111, 32'h00000001, 1'b0, 1'b1});
    vt.push_back('{3'd1, 3'd6, 7'h00, 32'hFFFFFFFF, 32'd1,        1'b1, 4'b1000, 32'h00000000, 1'b1, 1'b0});
    vt.push_back('{3'd1, 3'd7, 7'h00, 32'hFFFFFFFF, 32'd1,        1'b1, 4'b1000, 32'h00000000, 1'b1, 1'b1});
    vt.push_back('{3'd1, 3'd2, 7'h00, 32'hFFFFFFFF, 32'd1,        1'b1, 4'b0110, 32'hFFFFFFFE, 1'b0, 1'b0});
    vt.push_back('{3'd1, 3'd5, 7'h00, 32'd1,        32'hFFFFFFFF, 1'b1, 4'b0111, 32'h00000000, 1'b1, 1'b1});
    vt.push_back('{3'd2, 3'd0, 7'h00, 32'h7FFFFFFF, 32'd1,        1'b0, 4'b0010, 32'h80000000, 1'b0, 1'b0});
    vt.push_back('{3'd2, 3'd1, 7'h00, 32'd1,        32'h21,       1'b0, 4'b1010, 32'h00000002, 1'b0, 1'b0});
    vt.push_back('{3'd2, 3'd2, 7'h00, 32'hFFFFFFFE, 32'd3,        1'b0, 4'b0111, 32'h00000001, 1'b0, 1'b0});
    vt.push_back('{3'd2, 3'd3, 7'h00, 32'hFFFFFFFE, 32'd3,        1'b0, 4'b1000, 32'h00000000, 1'b1, 1'b0});
    vt.push_back('{3'd2, 3'd4, 7'h00, 32'hF0F0F0F0, 32'hFF00FF00, 1'b0, 4'b1001, 32'h0FF00FF0, 1'b0, 1'b0});
    vt.push_back('{3'd2, 3'd6, 7'h00, 32'hF0F0F0F0, 32'h0F0F0000, 1'b0, 4'b0001, 32'hFFFFF0F0, 1'b0, 1'b0});
    vt.push_back('{3'd2, 3'd7, 7'h00, 32'hF0F0F0F0, 32'h0FF00FF0, 1'b0, 4'b0000, 32'h00F000F0, 1'b0, 1'b0});
    vt.push_back('{3'd2, 3'd5, 7'h20, 32'h80000000, 32'h3F,       1'b0, 4'b1100, 32'hFFFFFFFF, 1'b0, 1'b0});
    vt.push_back('{3'd4, 3'd7, 7'h20, 32'd3,        32'd4,        1'b0, 4'b0010, 32'h00000007, 1'b0, 1'b0});
    vt.push_back('{3'd0, 3'd0, 7'h00, 32'd3,        32'hFFFFFFFD, 1'b1, 4'b0010, 32'h00000000, 1'b1, 1'b1});
    vt.push_back('{3'd3, 3'd2, 7'h7F, 32'd5,        32'hFFFFFFFF, 1'b0, 4'b0111, 32'h00000000, 1'b1, 1'b0});

    pin = model(3'd2, 3'd0, 7'h20, 32'd5, 32'd7, 1'b0);
    chk("model_sub_rc", pin.rc, 32'hFFFFFFFE);
    pin = model(3'd3, 3'd5, 7'h20, 32'h80000000, 32'd4, 1'b0);
    chk("model_srai_rc", pin.rc, 32'hF8000000);
    pin = model(3'd1, 3'd7, 7'h00, 32'hFFFFFFFF, 32'd1, 1'b1);
    chk("model_bgeu_db", {31'd0, pin.db}, 32'd1);

    // Reset held with a live vector on the inputs: registered outputs stay 0.
    rst = 1'b0;
    drive(vt[0]);
    repeat (2) @(posedge clk);
    #1;
    chk_reg_zero("reset");
    chk("reset_comb_rc", c_rc, 32'hFFFFFFFE);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("first_reg_rc", r_rc, 32'hFFFFFFFE);
    chk("first_reg_ctrl", {28'd0, r_ctrl}, 32'h6);

    foreach (vt[i]) begin
      drive(vt[i]);
      #2;
      chk($sformatf("v%0d_ctrl", i), {28'd0, c_ctrl}, {28'd0, vt[i].ctrl});
      chk($sformatf("v%0d_rc", i), c_rc, vt[i].rc);
      chk($sformatf("v%0d_z", i), {31'd0, c_z}, {31'd0, vt[i].z});
      chk($sformatf("v%0d_db", i), {31'd0, c_db}, {31'd0, vt[i].db});
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_reg_rc", i), r_rc, vt[i].rc);
      chk($sformatf("v%0d_reg_db", i), {31'd0, r_db}, {31'd0, vt[i].db});
    end

    // Mid-run reset overrides a taken BLT on the inputs.
    drive(vt[7]);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk_reg_zero("midreset");
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("post_reset_rc", r_rc, 32'd1);
    chk("post_reset_db", {31'd0, r_db}, 32'd1);
    chk("post_reset_ctrl", {28'd0, r_ctrl}, 32'h7);

    repeat (2) @(posedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
